// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the fetch stage (I-port) and
// the memory stage (D-port). One access is in flight at a time. D normally
// wins arbitration. After STARVE_MAX consecutive D grants while I is waiting,
// I is forced through.
//
// Handshake: a requester raises Req with its address/data and holds them
// until Gnt. Gnt is combinational in the issue cycle and is never asserted
// without Req. Dropping Req before Gnt is legal and issues nothing. The
// response is a one-cycle RValid pulse MEM_LAT cycles after the grant. A new
// grant may coincide with that pulse (back-to-back).
//
// Parameters
//   ADDR_W, DATA_W  address / data width of all ports
//   MEM_LAT         cycles from MemEn to valid MemRData (1..15)
//   STARVE_MAX      consecutive D grants with IReq pending before I is forced
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   IReq/IAddr -> IGnt             fetch request
//   IRValid/IRData                 fetch response
//   DReq/DWe/DAddr/DWData -> DGnt  data request
//   DRValid/DRData                 data response (DRData = 0 for writes)
//   MemEn/MemWe/MemAddr/MemWData   memory command (all 0 when MemEn = 0)
//   MemRData                       memory read data
//   StallF, StallM                 pipeline stall requests
//
// Optional feature (macro ARB_PERF_CNT_EN): adds IGntCnt, DGntCnt and
// ConflictCnt (issue cycles with both requests high). These are free-running
// 32-bit counters that wrap.
//
// The control FSM state is kept in the packed struct ctl_q
// (state/owner/write/latency count) for observation.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IGnt,
  output logic              IRValid,
  output logic [DATA_W-1:0] IRData,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DGnt,
  output logic              DRValid,
  output logic [DATA_W-1:0] DRData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              StallF,
  output logic              StallM
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       IGntCnt,
  output logic [31:0]       DGntCnt,
  output logic [31:0]       ConflictCnt
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_e;

  typedef struct packed {
    state_e     state;
    owner_e     owner;
    logic       wr;       // in-flight access is a D write
    logic [3:0] lat_cnt;  // cycles since issue, 1..MEM_LAT
  } ctl_t;

  ctl_t          ctl_q, ctl_d;
  logic [SW-1:0] starve_q, starve_d;

  logic resp;
  logic can_issue;
  logic force_i;
  logic d_win;
  logic i_win;
  logic issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q.state   <= ST_IDLE;
      ctl_q.owner   <= OWN_NONE;
      ctl_q.wr      <= 1'b0;
      ctl_q.lat_cnt <= 4'd0;
      starve_q      <= '0;
    end else begin
      ctl_q    <= ctl_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    ctl_d    = ctl_q;
    starve_d = starve_q;
    IGnt     = 1'b0;
    DGnt     = 1'b0;
    MemEn    = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    IRValid  = 1'b0;
    IRData   = '0;
    DRValid  = 1'b0;
    DRData   = '0;
    StallF   = 1'b0;
    StallM   = 1'b0;

    // The response cycle is the last cycle of the current access. It also
    // reopens the issue window so that back-to-back accesses reach one per
    // MEM_LAT cycles.
    resp      = (ctl_q.owner != OWN_NONE) && (ctl_q.lat_cnt == 4'(MEM_LAT));
    can_issue = (ctl_q.state == ST_IDLE) || resp;
    force_i   = IReq && (starve_q == SW'(STARVE_MAX));
    d_win     = DReq && !force_i;
    i_win     = IReq && !d_win;
    issue     = can_issue && (d_win || i_win);

    if (!rst) begin
      if (resp) begin
        if (ctl_q.owner == OWN_I) begin
          IRValid = 1'b1;
          IRData  = MemRData;
        end else begin
          DRValid = 1'b1;
          DRData  = ctl_q.wr ? '0 : MemRData;
        end
      end

      if (issue) begin
        MemEn = 1'b1;
        if (d_win) begin
          DGnt     = 1'b1;
          MemWe    = DWe;
          MemAddr  = DAddr;
          MemWData = DWData;
        end else begin
          IGnt    = 1'b1;
          MemAddr = IAddr;
        end
      end

      StallF = IReq && !IRValid;
      StallM = DReq && !DRValid;

      if (issue) begin
        // With single-cycle latency there are no dead cycles, so stay IDLE.
        ctl_d.state   = (MEM_LAT == 1) ? ST_IDLE : ST_WAIT;
        ctl_d.owner   = d_win ? OWN_D : OWN_I;
        ctl_d.wr      = d_win && DWe;
        ctl_d.lat_cnt = 4'd1;
      end else if (resp) begin
        ctl_d.state   = ST_IDLE;
        ctl_d.owner   = OWN_NONE;
        ctl_d.wr      = 1'b0;
        ctl_d.lat_cnt = 4'd0;
      end else if (ctl_q.owner != OWN_NONE) begin
        ctl_d.lat_cnt = ctl_q.lat_cnt + 4'd1;
      end

      // Counts only D grants that overtook a waiting fetch. The count
      // saturates and then forces the next grant to I.
      if (!IReq || (issue && i_win)) begin
        starve_d = '0;
      end else if (issue && d_win && (starve_q != SW'(STARVE_MAX))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_cnt_q, d_cnt_q, c_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      c_cnt_q <= '0;
    end else if (issue) begin
      if (d_win) d_cnt_q <= d_cnt_q + 32'd1;
      else       i_cnt_q <= i_cnt_q + 32'd1;
      if (IReq && DReq) c_cnt_q <= c_cnt_q + 32'd1;
    end
  end

  assign IGntCnt     = i_cnt_q;
  assign DGntCnt     = d_cnt_q;
  assign ConflictCnt = c_cnt_q;
`endif

endmodule
